// File: rtl/opm_seq_pkg.sv
// Shared types and defaults for the OPM delay-line sequencer and its delay-line instances.
package opm_seq_pkg;

  // Defaults shared with the EBR delay-line instances driven by the sequencer.
  localparam int unsigned DefStages = 32;
  localparam int unsigned DefDiv    = 4;

  typedef enum logic [1:0] {
    StWipe,
    StIdle,
    StRun
  } seq_state_e;

  // Bits needed to hold 0..n-1, never less than one.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(n)) r = i + 1;
    end
    return (r == 0) ? 1 : r;
  endfunction

endpackage

// File: rtl/ebr_sh_seq_if.sv
// Control bundle between the sequencer (master) and its requester/delay lines (slave).
interface ebr_sh_seq_if
  import opm_seq_pkg::*;
#(
  parameter int unsigned STAGES = DefStages
) ();

  localparam int unsigned SlotW = clog2(STAGES);

  logic             run;
  logic             wipe_req;
  logic             cen;
  logic             sh_rst;
  logic [SlotW-1:0] slot;
  logic             sync;
  logic             busy;

  modport master (
    input  run,
    input  wipe_req,
    output cen,
    output sh_rst,
    output slot,
    output sync,
    output busy
  );

  modport slave (
    output run,
    output wipe_req,
    input  cen,
    input  sh_rst,
    input  slot,
    input  sync,
    input  busy
  );

endinterface

// File: rtl/opm_cen_div.sv
// Prescaler: one-clock registered tick every DIV enabled clocks, restartable by clr_i.
module opm_cen_div
  import opm_seq_pkg::*;
#(
  parameter int unsigned DIV = DefDiv
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic tick_o,
  // Value tick_o will take after the next edge; lets the parent align other outputs.
  output logic tick_nxt_o
);

  localparam int unsigned CntW = clog2(DIV);
  localparam logic [CntW-1:0] CntLast = CntW'(DIV - 1);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            tick_q, tick_d;

  // Count enabled clocks, wrapping at DIV-1; clear or disable parks the count at zero.
  always_comb begin
    cnt_d  = cnt_q;
    tick_d = 1'b0;
    if (clr_i || !en_i) begin
      cnt_d = '0;
    end else begin
      tick_d = (cnt_q == CntLast);
      cnt_d  = (cnt_q == CntLast) ? '0 : cnt_q + 1'b1;
    end
  end

  // Counter and tick registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  assign tick_o     = tick_q;
  assign tick_nxt_o = tick_d;

endmodule

// File: rtl/ebr_sh_seq.sv
// Slot sequencer and wipe controller for slot-multiplexed EBR delay lines.
module ebr_sh_seq
  import opm_seq_pkg::*;
#(
  parameter int unsigned STAGES      = DefStages,
  parameter int unsigned DIV         = DefDiv,
  parameter int unsigned WIPE_PASSES = 1
) (
  input logic         clk,
  input logic         rst,
  ebr_sh_seq_if.master bus
);

  localparam int unsigned SlotW     = clog2(STAGES);
  localparam int unsigned WipeTotal = STAGES * WIPE_PASSES;
  localparam int unsigned WcntW     = clog2(WipeTotal);
  localparam logic [SlotW-1:0] SlotLast = SlotW'(STAGES - 1);
  localparam logic [WcntW-1:0] WcntLast = WcntW'(WipeTotal - 1);

  seq_state_e       state_q, state_d;
  logic [SlotW-1:0] slot_q, slot_d;
  logic [WcntW-1:0] wcnt_q, wcnt_d;
  logic             pend_q, pend_d;
  logic             sh_rst_q, sh_rst_d;
  logic             busy_q, busy_d;
  logic             sync_q, sync_d;

  logic cen;
  logic cen_nxt;
  logic enter;
  logic div_en;
  logic frame_end;
  logic wipe_done;

  // A pending or same-cycle wipe request both count at the frame-end decision.
  assign frame_end = cen && (slot_q == SlotLast);
  assign wipe_done = cen && (wcnt_q == WcntLast);

  // Entering WIPE or RUN restarts divider, slot and wipe counters.
  assign enter  = (state_d != state_q) && (state_d != StIdle);
  assign div_en = (state_d != StIdle) && !enter;

  opm_cen_div #(
    .DIV (DIV)
  ) u_cen_div (
    .clk        (clk),
    .rst        (rst),
    .clr_i      (enter),
    .en_i       (div_en),
    .tick_o     (cen),
    .tick_nxt_o (cen_nxt)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= StWipe;
    else     state_q <= state_d;
  end

  // Next-state: all decisions except IDLE exits are taken on a cen pulse.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StWipe: begin
        if (wipe_done) state_d = bus.run ? StRun : StIdle;
      end
      StIdle: begin
        if (bus.wipe_req)  state_d = StWipe;
        else if (bus.run)  state_d = StRun;
      end
      StRun: begin
        if (frame_end) begin
          if (pend_q || bus.wipe_req) state_d = StWipe;
          else if (!bus.run)          state_d = StIdle;
        end
      end
      default: state_d = StWipe;
    endcase
  end

  // Output and counter next values; everything leaving the block is registered.
  always_comb begin
    slot_d = slot_q;
    if (enter || (state_d == StIdle)) slot_d = '0;
    else if (cen)                     slot_d = (slot_q == SlotLast) ? '0 : slot_q + 1'b1;

    wcnt_d = wcnt_q;
    if (enter || (state_d != StWipe)) wcnt_d = '0;
    else if (cen)                     wcnt_d = wcnt_q + 1'b1;

    // Requests only latch while RUN continues; WIPE ignores them.
    pend_d = 1'b0;
    if ((state_q == StRun) && (state_d == StRun)) pend_d = pend_q || bus.wipe_req;

    sh_rst_d = (state_d == StWipe);
    busy_d   = (state_d == StWipe);
    sync_d   = cen_nxt && (state_d == StRun) && (slot_d == '0);
  end

  // Counter, pending flag and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      slot_q   <= '0;
      wcnt_q   <= '0;
      pend_q   <= 1'b0;
      sh_rst_q <= 1'b1;
      busy_q   <= 1'b1;
      sync_q   <= 1'b0;
    end else begin
      slot_q   <= slot_d;
      wcnt_q   <= wcnt_d;
      pend_q   <= pend_d;
      sh_rst_q <= sh_rst_d;
      busy_q   <= busy_d;
      sync_q   <= sync_d;
    end
  end

  assign bus.cen    = cen;
  assign bus.sh_rst = sh_rst_q;
  assign bus.slot   = slot_q;
  assign bus.sync   = sync_q;
  assign bus.busy   = busy_q;

endmodule
